arb_rr_ctrl: RTL and testbench

Round-robin arbiter that drives the gnt side of the shared arbitration interface. It receives per-agent req bits and issues at most one one-hot gnt at a time. The grant is held until the owner drops req, or is optionally revoked after a maximum tenure. It sits between the requesting agents and the shared resource, and is the only driver of gnt.

---
 rtl/arb_pkg.sv | 23 ++
 rtl/arb_rr_pick.sv | 45 ++++
 rtl/arb_rr_ctrl.sv | 167 ++++++++++++++++
 tb/tb_arb_rr_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
//   Shared definitions for the round-robin arbiter family.
//   - arb_state_e : arbiter FSM states (IDLE, GRANT, GAP)
//   - HOLD_W      : width of the grant tenure counter
//   - calc_idw()  : width of an agent index, never less than 1 bit
// ----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    localparam int HOLD_W = 8;

    // A single agent still needs a 1-bit index port.
    function automatic int calc_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// ----------------------------------------------------------------------------
// arb_rr_pick
//   Combinational round-robin priority picker. Returns the first set request
//   bit found searching upward from i_ptr, wrapping past the top agent.
//   The request vector is doubled and shifted down by the pointer, so the
//   wrap-around becomes a plain lowest-set-bit scan.
//
// Ports:
//   i_req    [N-1:0]   request vector
//   i_ptr    [IDW-1:0] search start index (0..N-1)
//   o_winner [IDW-1:0] index of the selected agent (0 when none)
//   o_any              high when any request bit is set
// ----------------------------------------------------------------------------
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = calc_idw(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [IDW-1:0] o_winner,
    output logic           o_any
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        w_dbl    = {i_req, i_req};
        w_rot    = N'(w_dbl >> i_ptr);
        o_winner = '0;
        // Scan from the top down so the lowest rotated position wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                o_winner = IDW'((int'(i_ptr) + i) % N);
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/arb_rr_ctrl.sv
// ----------------------------------------------------------------------------
// arb_rr_ctrl
//   Round-robin arbiter driving the gnt side of the shared arbitration
//   interface. Issues at most one one-hot grant, held until the owner drops
//   its request. Every grant is followed by one GAP cycle, so two grants are
//   always separated by two cycles with gnt=0.
//
//   Optional tenure limit, enabled by defining ARB_TENURE_LIMIT_EN: a grant
//   that has lasted MAX_HOLD cycles is revoked (one-cycle revoke pulse) when
//   any other agent is requesting. Without the macro the hold counter does
//   not exist and revoke is tied low.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req        per-agent level request
//   gnt        registered one-hot grant, or all zeros
//   owner      index of the current grantee (holds last value when idle)
//   owner_vld  high exactly when gnt != 0
//   revoke     one-cycle pulse when the tenure limit ends a grant
// ----------------------------------------------------------------------------
module arb_rr_ctrl
    import arb_pkg::*;
#(
    parameter int  num_agents = 4,
    parameter int  MAX_HOLD   = 16,
    localparam int IDW        = calc_idw(num_agents)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [num_agents-1:0] req,
    output logic [num_agents-1:0] gnt,
    output logic [IDW-1:0]        owner,
    output logic                  owner_vld,
    output logic                  revoke
);

    if (num_agents < 1 || num_agents > 32) begin : g_bad_num_agents
        $error("arb_rr_ctrl: num_agents out of range 1..32");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("arb_rr_ctrl: MAX_HOLD out of range 2..255");
    end

    arb_state_e            r_state;
    logic [num_agents-1:0] r_gnt;
    logic [IDW-1:0]        r_owner;
    logic                  r_owner_vld;
    logic [IDW-1:0]        r_ptr;

    logic [IDW-1:0]        w_winner;
    logic                  w_any;
    logic [num_agents-1:0] w_win_onehot;
    logic                  w_owner_req;
    logic [IDW-1:0]        w_next_ptr;

`ifdef ARB_TENURE_LIMIT_EN
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] r_hold;
    logic              r_revoke;
    logic              w_others;

    assign w_others = |(req & ~r_gnt);
`endif

    arb_rr_pick #(
        .N   (num_agents),
        .IDW (IDW)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Index decode done by comparison so a single-agent build never
    // indexes with a wider-than-needed pointer.
    always_comb begin
        w_owner_req  = 1'b0;
        w_win_onehot = '0;
        for (int i = 0; i < num_agents; i++) begin
            if (IDW'(i) == r_owner) begin
                w_owner_req = req[i];
            end
            if (IDW'(i) == w_winner) begin
                w_win_onehot[i] = 1'b1;
            end
        end
    end

    // Next search start is one past the releasing owner, wrapping to 0.
    assign w_next_ptr = (int'(r_owner) == num_agents - 1) ? '0 : r_owner + IDW'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_owner     <= '0;
            r_owner_vld <= 1'b0;
            r_ptr       <= '0;
`ifdef ARB_TENURE_LIMIT_EN
            r_hold      <= '0;
            r_revoke    <= 1'b0;
`endif
        end else begin
`ifdef ARB_TENURE_LIMIT_EN
            r_revoke <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state     <= GRANT;
                        r_gnt       <= w_win_onehot;
                        r_owner     <= w_winner;
                        r_owner_vld <= 1'b1;
`ifdef ARB_TENURE_LIMIT_EN
                        r_hold      <= '0;
`endif
                    end
                end

                GRANT: begin
                    // Owner release takes precedence over the tenure limit.
                    if (!w_owner_req) begin
                        r_state     <= GAP;
                        r_gnt       <= '0;
                        r_owner_vld <= 1'b0;
                        r_ptr       <= w_next_ptr;
                    end
`ifdef ARB_TENURE_LIMIT_EN
                    else if (r_hold == HOLD_MAX && w_others) begin
                        r_state     <= GAP;
                        r_gnt       <= '0;
                        r_owner_vld <= 1'b0;
                        r_ptr       <= w_next_ptr;
                        r_revoke    <= 1'b1;
                    end else if (r_hold != HOLD_MAX) begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
`endif
                end

                GAP: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign owner     = r_owner;
    assign owner_vld = r_owner_vld;

`ifdef ARB_TENURE_LIMIT_EN
    assign revoke = r_revoke;
`else
    assign revoke = 1'b0;
`endif

endmodule

// File: tb/tb_arb_rr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_arb_rr_ctrl
//   Bench for arb_rr_ctrl: a 4-agent instance (MAX_HOLD=4) and a 1-agent
//   instance share clock and reset. Directed table vectors, hand sequences
//   for tenure/reset/single-agent corners, then random requests compared
//   against a behavioural model of the arbitration rules.
// ----------------------------------------------------------------------------
module tb_arb_rr_ctrl;

    localparam int MH = 4;
`ifdef ARB_TENURE_LIMIT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req4 = '0;
    logic [3:0] gnt4;
    logic [1:0] own4;
    logic       vld4;
    logic       rev4;
    logic [0:0] req1 = '0;
    logic [0:0] gnt1;
    logic [0:0] own1;
    logic       vld1;
    logic       rev1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arb_rr_ctrl #(.num_agents(4), .MAX_HOLD(MH)) u_dut4 (
        .clk(clk), .reset(rst_n), .req(req4), .gnt(gnt4),
        .owner(own4), .owner_vld(vld4), .revoke(rev4)
    );

    arb_rr_ctrl #(.num_agents(1), .MAX_HOLD(MH)) u_dut1 (
        .clk(clk), .reset(rst_n), .req(req1), .gnt(gnt1),
        .owner(own1), .owner_vld(vld1), .revoke(rev1)
    );

    // ---------------- behavioural model ----------------
    // Per instance: current owner (-1 = none), search start, cycles granted,
    // edges still to wait after a release before arbitrating again.
    int   mn[2] = '{4, 1};
    int   m_owner[2];
    int   m_ptr[2];
    int   m_ten[2];
    int   m_cool[2];
    logic m_rev[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_ptr[k] = 0; m_ten[k] = 0; m_cool[k] = 0; m_rev[k] = 1'b0;
        end
    endtask

    task automatic model_drop(input int k);
        m_ptr[k]   = (m_owner[k] + 1) % mn[k];
        m_owner[k] = -1;
        m_cool[k]  = 1;
    endtask

    task automatic model_step(input int k, input logic [3:0] r);
        m_rev[k] = 1'b0;
        if (m_owner[k] >= 0) begin
`ifdef ARB_TENURE_LIMIT_EN
            logic [3:0] others;
            others = r;
            others[m_owner[k]] = 1'b0;
            if (!r[m_owner[k]]) model_drop(k);
            else if (m_ten[k] >= MH && others != 4'b0) begin
                model_drop(k);
                m_rev[k] = 1'b1;
            end else m_ten[k]++;
`else
            if (!r[m_owner[k]]) model_drop(k);
            else m_ten[k]++;
`endif
        end else if (m_cool[k] > 0) begin
            m_cool[k]--;
        end else begin
            for (int j = 0; j < mn[k]; j++) begin
                int a = (m_ptr[k] + j) % mn[k];
                if (m_owner[k] < 0 && r[a]) begin
                    m_owner[k] = a;
                    m_ten[k]   = 1;
                end
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: drive, let one rising edge pass, return at negedge.
    task automatic step(input logic [3:0] r4, input logic r1);
        req4 = r4;
        req1 = r1;
        @(posedge clk);
        model_step(0, r4);
        model_step(1, {3'b000, r1});
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req4  = '0;
        req1  = '0;
        #1;
        check("rst_gnt4", 32'(gnt4), 32'h0);
        check("rst_vld4", 32'(vld4), 32'h0);
        check("rst_rev4", 32'(rev4), 32'h0);
        check("rst_own4", 32'(own4), 32'h0);
        check("rst_gnt1", 32'(gnt1), 32'h0);
        check("rst_vld1", 32'(vld1), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic expect4(input string name, input logic [3:0] g, input logic [1:0] o, input logic rv);
        check({name, "_gnt"}, 32'(gnt4), 32'(g));
        check({name, "_vld"}, 32'(vld4), 32'(g != 4'b0));
        check({name, "_rev"}, 32'(rev4), 32'(rv));
        if (g != 4'b0) check({name, "_own"}, 32'(own4), 32'(o));
    endtask

    task automatic compare_model();
        logic [3:0] e4;
        e4 = (m_owner[0] >= 0) ? 4'(1 << m_owner[0]) : 4'b0;
        check("rnd_gnt4", 32'(gnt4), 32'(e4));
        check("rnd_vld4", 32'(vld4), 32'(m_owner[0] >= 0));
        check("rnd_rev4", 32'(rev4), 32'(m_rev[0]));
        if (m_owner[0] >= 0) check("rnd_own4", 32'(own4), 32'(m_owner[0]));
        check("rnd_gnt1", 32'(gnt1), 32'(m_owner[1] >= 0));
        check("rnd_vld1", 32'(vld1), 32'(m_owner[1] >= 0));
        check("rnd_rev1", 32'(rev1), 32'(m_rev[1]));
        check("rnd_own1", 32'(own1), 32'h0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] own;
    } vec_t;

    vec_t tab[$];

    initial begin
        logic [3:0] r4;
        logic       r1;
        logic [0:0] n1_req[6];
        logic [0:0] n1_exp[6];

        model_reset();

        // Reset release, single request, release, wrap-around from ptr=3.
        tab.push_back('{1'b1, 4'b0100, 4'b0100, 2'd2});
        tab.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0});
        tab.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0});
        tab.push_back('{1'b0, 4'b0011, 4'b0001, 2'd0});
        tab.push_back('{1'b0, 4'b0010, 4'b0000, 2'd0});
        tab.push_back('{1'b0, 4'b0010, 4'b0000, 2'd0});
        tab.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1});
        tab.push_back('{1'b0, 4'b1111, 4'b0010, 2'd1});
        tab.push_back('{1'b0, 4'b0110, 4'b0010, 2'd1});
        tab.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0});
        tab.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0});
        // Round robin with all requesting, each owner dropping after 3 cycles.
        for (int a = 0; a < 5; a++) begin
            logic [3:0] oh;
            oh = 4'(1 << (a % 4));
            tab.push_back('{(a == 0), 4'b1111, oh, 2'(a % 4)});
            tab.push_back('{1'b0, 4'b1111, oh, 2'(a % 4)});
            tab.push_back('{1'b0, 4'b1111, oh, 2'(a % 4)});
            if (a < 4) begin
                tab.push_back('{1'b0, 4'b1111 & ~oh, 4'b0000, 2'd0});
                tab.push_back('{1'b0, 4'b1111, 4'b0000, 2'd0});
            end
        end

        for (int i = 0; i < tab.size(); i++) begin
            if (tab[i].rst) do_reset();
            step(tab[i].req, 1'b0);
            expect4($sformatf("tab%0d", i), tab[i].gnt, tab[i].own, 1'b0);
        end

        // Tenure limit: agent 1 owns, agent 3 requests throughout.
        do_reset();
        step(4'b0010, 1'b0);
        expect4("ten_start", 4'b0010, 2'd1, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            step(4'b1010, 1'b0);
            expect4($sformatf("ten_hold%0d", c), 4'b0010, 2'd1, 1'b0);
        end
        step(4'b1010, 1'b0);
        expect4("ten_limit", TEN ? 4'b0000 : 4'b0010, 2'd1, TEN);
        step(4'b1010, 1'b0);
        expect4("ten_gap", TEN ? 4'b0000 : 4'b0010, 2'd1, 1'b0);
        step(4'b1010, 1'b0);
        expect4("ten_next", TEN ? 4'b1000 : 4'b0010, TEN ? 2'd3 : 2'd1, 1'b0);

        // Sole requester keeps the grant past the limit; a late rival
        // triggers the revoke at once because the counter stays saturated.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step(4'b0010, 1'b0);
            expect4($sformatf("solo%0d", c), 4'b0010, 2'd1, 1'b0);
        end
        step(4'b1010, 1'b0);
        expect4("solo_rival", TEN ? 4'b0000 : 4'b0010, 2'd1, TEN);

        // Owner drops exactly when the limit is reached: plain release.
        do_reset();
        for (int c = 0; c < 4; c++) step(4'b0010, 1'b0);
        expect4("sim_held", 4'b0010, 2'd1, 1'b0);
        step(4'b1000, 1'b0);
        expect4("sim_drop", 4'b0000, 2'd0, 1'b0);
        step(4'b1000, 1'b0);
        expect4("sim_gap", 4'b0000, 2'd0, 1'b0);
        step(4'b1000, 1'b0);
        expect4("sim_next", 4'b1000, 2'd3, 1'b0);

        // Async reset mid-grant, then restart with agent 3 only.
        do_reset();
        step(4'b0100, 1'b0);
        step(4'b0101, 1'b0);
        expect4("mid_pre", 4'b0100, 2'd2, 1'b0);
        do_reset();
        step(4'b1000, 1'b0);
        expect4("mid_post", 4'b1000, 2'd3, 1'b0);

        // Single agent: req 1,1,0,1,1,1.
        do_reset();
        n1_req = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        n1_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int c = 0; c < 6; c++) begin
            step(4'b0000, n1_req[c][0]);
            check($sformatf("one%0d_gnt", c), 32'(gnt1), 32'(n1_exp[c]));
            check($sformatf("one%0d_vld", c), 32'(vld1), 32'(n1_exp[c]));
            check($sformatf("one%0d_own", c), 32'(own1), 32'h0);
            check($sformatf("one%0d_rev", c), 32'(rev1), 32'h0);
        end

        // Random requests against the model.
        do_reset();
        r4 = '0;
        r1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 6) == 0) r4[b] = ~r4[b];
            end
            if ($urandom_range(0, 4) == 0) r1 = ~r1;
            step(r4, r1);
            compare_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
